// File: rtl/d_register.sv
// Parameterised D register: q follows d one clk edge later, loaded with RST_VAL
// on any edge where RST is high.
module d_register #(
  parameter int unsigned        numBit  = 10,
  parameter logic [numBit-1:0]  RST_VAL = '0
) (
  input  logic              clk,
  input  logic              RST,
  input  logic [numBit-1:0] d,
  output logic [numBit-1:0] q
);

  logic [numBit-1:0] r_q;

  // Reset has priority over data sampled on the same edge.
  always_ff @(posedge clk) begin
    if (RST) begin
      r_q <= RST_VAL;
    end else begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: tb/tb_d_register.sv
// Randomised and directed bench for d_register: the expected q is simply whatever
// reset/data pair was present at the most recent rising edge.
module tb_d_register;

  localparam logic [9:0] RV_B = 10'h155;

  logic       clk;
  logic       RST;
  logic [9:0] d;
  logic [9:0] q_a;
  logic [9:0] q_b;
  logic [0:0] q_c;

  int checks;
  int errors;

  // Values q is expected to hold since the last edge.
  logic [9:0] exp_a;
  logic [9:0] exp_b;
  logic [0:0] exp_c;

  d_register #(.numBit(10)) u_dut_a (
    .clk (clk),
    .RST (RST),
    .d   (d),
    .q   (q_a)
  );

  d_register #(.numBit(10), .RST_VAL(RV_B)) u_dut_b (
    .clk (clk),
    .RST (RST),
    .d   (d),
    .q   (q_b)
  );

  d_register #(.numBit(1)) u_dut_c (
    .clk (clk),
    .RST (RST),
    .d   (d[0:0]),
    .q   (q_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/a"}, q_a, exp_a);
    chk({tag, "/b"}, q_b, exp_b);
    chk({tag, "/c"}, {9'b0, q_c}, {9'b0, exp_c});
  endtask

  // The reference: whatever sits on RST/d at the edge decides q afterwards.
  task automatic model_edge();
    if (RST) begin
      exp_a = 10'h000;
      exp_b = RV_B;
      exp_c = 1'b0;
    end else begin
      exp_a = d;
      exp_b = d;
      exp_c = d[0:0];
    end
  endtask

  // Drive inputs, take one edge, check 1 time unit after it.
  task automatic cycle(input logic rst, input logic [9:0] dv, input string tag);
    RST = rst;
    d   = dv;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
    $display("txn %-10s RST=%0b d=%h q_a=%h q_b=%h q_c=%0b", tag, rst, dv, q_a, q_b, q_c);
  endtask

  // Wiggle RST and d between edges, verify q is untouched, then settle on final values.
  task automatic glitch_cycle(input logic rst, input logic [9:0] dv, input string tag);
    d = 10'h155; RST = 1'b1;
    #2 d = 10'h2AA; RST = 1'b0;
    #2 d = 10'h155; RST = 1'b1;
    #1 check_all({tag, "_mid"});
    #1 RST = rst; d = dv;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
    $display("txn %-10s RST=%0b d=%h q_a=%h q_b=%h q_c=%0b", tag, rst, dv, q_a, q_b, q_c);
  endtask

  initial begin
    logic [9:0] rd;
    logic       rr;
    checks = 0;
    errors = 0;
    RST = 1'b1;
    d   = 10'h3FF;
    exp_a = 'x; exp_b = 'x; exp_c = 'x;
    @(negedge clk);

    // 1: reset held with all-ones data.
    for (int i = 0; i < 4; i++) cycle(1'b1, 10'h3FF, "rst_hold");

    // 2: release with no dead cycle, then hold.
    cycle(1'b0, 10'h3FF, "release");
    for (int i = 0; i < 6; i++) cycle(1'b0, 10'h3FF, "hold");

    // 3: q must not move before the edge.
    d = 10'h000;
    #3 check_all("pre_edge");
    cycle(1'b0, 10'h000, "fall");

    // 4: walking one.
    for (int i = 0; i < 10; i++) cycle(1'b0, 10'(1) << i, "walk1");

    // 5: mid-cycle glitches on d and RST.
    glitch_cycle(1'b0, 10'h155, "glitch_d");
    glitch_cycle(1'b0, 10'h2AA, "glitch_d2");
    glitch_cycle(1'b1, 10'h2AA, "glitch_rst");
    glitch_cycle(1'b0, 10'h3C3, "glitch_rel");

    // 6: single-edge reset inside a stream.
    cycle(1'b0, 10'h2AA, "stream");
    cycle(1'b1, 10'h2AA, "pulse_rst");
    cycle(1'b0, 10'h2AA, "pulse_rel");

    // Random traffic with occasional reset.
    for (int i = 0; i < 200; i++) begin
      rd = 10'($urandom);
      rr = ($urandom_range(0, 15) == 0);
      cycle(rr, rd, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
